// File: rtl/vt_meas_sequencer_pkg.sv
// rtl/vt_meas_sequencer_pkg.sv - shared constants, FSM encodings and RO index map for the VT sequencer
package vt_pkg;

  localparam int NUM_RO    = 9;
  localparam int CNT_W     = 16;
  localparam int TDC_W     = 48;
  localparam int TDC_ENC_W = 6;
  localparam int IDX_W     = 4;
  localparam int SETTLE    = 4;
  localparam int CAP_DLY   = 3;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SELECT  = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_CAPTURE = 3'd4;
  localparam logic [2:0] ST_WAIT    = 3'd5;
  localparam logic [2:0] ST_FINISH  = 3'd6;

  typedef enum logic [IDX_W-1:0] {
    RO_INV_HVT   = 4'd0,
    RO_INV_RVT   = 4'd1,
    RO_INV_LVT   = 4'd2,
    RO_NAND2_HVT = 4'd3,
    RO_NAND2_RVT = 4'd4,
    RO_NAND2_LVT = 4'd5,
    RO_NOR2_HVT  = 4'd6,
    RO_NOR2_RVT  = 4'd7,
    RO_NOR4_RVT  = 4'd8
  } ro_idx_e;

  // Returns {found, index of lowest set bit}.
  function automatic logic [IDX_W:0] first_set(input logic [NUM_RO-1:0] v);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = NUM_RO - 1; i >= 0; i--) begin
      if (v[i]) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/vt_meas_sequencer_if.sv
// rtl/vt_meas_sequencer_if.sv - sequencer control, sensor and result signals with sequencer/host modports
interface vt_meas_sequencer_if;
  import vt_pkg::*;

  logic                 START;
  logic [NUM_RO-1:0]    MASK;
  logic [7:0]           WINDOW;
  logic [NUM_RO-1:0]    RO_SEL;
  logic [3:0]           MUX_SEL;
  logic                 RO_EN;
  logic                 CNT_RSTLOW;
  logic [CNT_W-1:0]     CNT_IN;
  logic [TDC_W-1:0]     TDC_IN;
  logic                 RES_VALID;
  logic                 RES_READY;
  logic [3:0]           RES_ID;
  logic [CNT_W-1:0]     RES_CNT;
  logic [TDC_ENC_W-1:0] RES_TDC;
  logic                 BUSY;
  logic                 DONE;

  modport master (
    input  START, MASK, WINDOW, CNT_IN, TDC_IN, RES_READY,
    output RO_SEL, MUX_SEL, RO_EN, CNT_RSTLOW, RES_VALID, RES_ID, RES_CNT, RES_TDC, BUSY, DONE
  );

  modport slave (
    output START, MASK, WINDOW, CNT_IN, TDC_IN, RES_READY,
    input  RO_SEL, MUX_SEL, RO_EN, CNT_RSTLOW, RES_VALID, RES_ID, RES_CNT, RES_TDC, BUSY, DONE
  );

endinterface

// File: rtl/vt_meas_sequencer_therm_encoder.sv
// rtl/vt_meas_sequencer_therm_encoder.sv - bubble-tolerant thermometer encoder (popcount)
module vt_therm_encoder
  import vt_pkg::*;
#(
  parameter int W     = TDC_W,
  parameter int ENC_W = TDC_ENC_W
) (
  input  logic [W-1:0]     therm,
  output logic [ENC_W-1:0] code
);

  // Counting ones rather than locating the edge keeps isolated bubbles from skewing the result.
  always_comb begin
    code = '0;
    for (int i = 0; i < W; i++) begin
      code = code + ENC_W'(therm[i]);
    end
  end

endmodule

// File: rtl/vt_meas_sequencer.sv
// rtl/vt_meas_sequencer.sv - per-RO select/settle/run/hold/capture sweep with valid/ready result output
module vt_meas_sequencer
  import vt_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  vt_meas_sequencer_if.master bus
);

  logic [2:0]           state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [NUM_RO-1:0]    mask_q, mask_d;
  logic [7:0]           win_q, win_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_RO-1:0]    ro_sel_q, ro_sel_d;
  logic [3:0]           mux_sel_q, mux_sel_d;
  logic                 ro_en_q, ro_en_d;
  logic                 cnt_rstlow_q, cnt_rstlow_d;
  logic                 res_valid_q, res_valid_d;
  logic [3:0]           res_id_q, res_id_d;
  logic [CNT_W-1:0]     res_cnt_q, res_cnt_d;
  logic [TDC_ENC_W-1:0] res_tdc_q, res_tdc_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [TDC_ENC_W-1:0] tdc_code;
  logic [NUM_RO-1:0]    above;
  logic [IDX_W:0]       first_hit, next_hit;
  logic [7:0]           win_last;

  vt_therm_encoder u_enc (
    .therm (bus.TDC_IN),
    .code  (tdc_code)
  );

  // A zero window still gets one enable cycle.
  assign win_last  = (win_q == 8'd0) ? 8'd0 : win_q - 8'd1;
  assign first_hit = first_set(bus.MASK);
  assign next_hit  = first_set(above);

  always_comb begin
    above = '0;
    for (int i = 0; i < NUM_RO; i++) begin
      above[i] = mask_q[i] & (IDX_W'(i) > idx_q);
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mask_d       = mask_q;
    win_d        = win_q;
    idx_d        = idx_q;
    ro_sel_d     = ro_sel_q;
    mux_sel_d    = mux_sel_q;
    ro_en_d      = ro_en_q;
    cnt_rstlow_d = cnt_rstlow_q;
    res_valid_d  = res_valid_q;
    res_id_d     = res_id_q;
    res_cnt_d    = res_cnt_q;
    res_tdc_d    = res_tdc_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          mask_d = bus.MASK;
          win_d  = bus.WINDOW;
          busy_d = 1'b1;
          cnt_d  = 8'd0;
          if (first_hit[IDX_W]) begin
            idx_d   = first_hit[IDX_W-1:0];
            state_d = ST_SELECT;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_SELECT: begin
        ro_sel_d     = NUM_RO'(1) << idx_q;
        mux_sel_d    = idx_q;
        cnt_rstlow_d = 1'b0;
        if (cnt_q == 8'(SETTLE - 1)) begin
          cnt_d   = 8'd0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RUN: begin
        cnt_rstlow_d = 1'b1;
        ro_en_d      = 1'b1;
        if (cnt_q == win_last) begin
          cnt_d   = 8'd0;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_HOLD: begin
        ro_en_d = 1'b0;
        if (cnt_q == 8'(CAP_DLY - 1)) begin
          cnt_d   = 8'd0;
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_CAPTURE: begin
        res_cnt_d   = bus.CNT_IN;
        res_tdc_d   = tdc_code;
        res_id_d    = idx_q;
        res_valid_d = 1'b1;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        // RO_SEL stays on the finished RO until the consumer takes the result.
        if (bus.RES_READY) begin
          res_valid_d = 1'b0;
          cnt_d       = 8'd0;
          if (next_hit[IDX_W]) begin
            idx_d   = next_hit[IDX_W-1:0];
            state_d = ST_SELECT;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        done_d   = 1'b1;
        busy_d   = 1'b0;
        ro_sel_d = '0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      mask_q       <= '0;
      win_q        <= '0;
      idx_q        <= '0;
      ro_sel_q     <= '0;
      mux_sel_q    <= '0;
      ro_en_q      <= 1'b0;
      cnt_rstlow_q <= 1'b1;
      res_valid_q  <= 1'b0;
      res_id_q     <= '0;
      res_cnt_q    <= '0;
      res_tdc_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      win_q        <= win_d;
      idx_q        <= idx_d;
      ro_sel_q     <= ro_sel_d;
      mux_sel_q    <= mux_sel_d;
      ro_en_q      <= ro_en_d;
      cnt_rstlow_q <= cnt_rstlow_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_cnt_q    <= res_cnt_d;
      res_tdc_q    <= res_tdc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.RO_SEL     = ro_sel_q;
  assign bus.MUX_SEL    = mux_sel_q;
  assign bus.RO_EN      = ro_en_q;
  assign bus.CNT_RSTLOW = cnt_rstlow_q;
  assign bus.RES_VALID  = res_valid_q;
  assign bus.RES_ID     = res_id_q;
  assign bus.RES_CNT    = res_cnt_q;
  assign bus.RES_TDC    = res_tdc_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;

endmodule

// File: tb/tb_vt_meas_sequencer.sv
// tb/tb_vt_meas_sequencer.sv - randomized scoreboard bench for vt_meas_sequencer
module tb_vt_meas_sequencer;

  typedef struct {
    logic [3:0]  id;
    logic [15:0] cnt;
    logic [5:0]  tdc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vt_meas_sequencer_if ifc ();

  vt_meas_sequencer dut (
    .CLK (clk),
    .RST (rst),
    .bus (ifc)
  );

  exp_t        exp_q[$];
  logic [15:0] cnt_tab [9];
  logic [47:0] tdc_tab [9];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          t0 = 0;
  int          exp_win = 1;
  int          exp_lat = 0;
  int          first_seen = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          busy_cyc = 0;
  int          rdy_hold = 0;
  bit          rdy_rand = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Sensor model: counter and TDC outputs follow whichever RO is selected.
  always_comb begin
    ifc.CNT_IN = cnt_tab[0];
    ifc.TDC_IN = tdc_tab[0];
    for (int i = 1; i < 9; i++) begin
      if (ifc.RO_SEL[i]) begin
        ifc.CNT_IN = cnt_tab[i];
        ifc.TDC_IN = tdc_tab[i];
      end
    end
  end

  initial begin
    ifc.RES_READY = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_hold > 0) begin
        ifc.RES_READY = 1'b0;
        if (ifc.RES_VALID) rdy_hold--;
      end else begin
        ifc.RES_READY = rdy_rand ? 1'($urandom) : 1'b1;
      end
    end
  end

  initial begin : monitor
    int   run;
    bit   prev_v;
    exp_t e;
    logic [3:0]  h_id;
    logic [15:0] h_cnt;
    logic [5:0]  h_tdc;
    run = 0;
    prev_v = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run = 0;
        prev_v = 0;
      end else begin
        chk("ro_sel_onehot", 64'($countones(ifc.RO_SEL) <= 1), 64'd1);
        if (ifc.RO_SEL != 0) chk("mux_matches_sel", 64'(ifc.RO_SEL), 64'(9'd1 << ifc.MUX_SEL));
        if (ifc.RO_EN) chk("rstlow_during_en", 64'(ifc.CNT_RSTLOW), 64'd1);
        if (ifc.RO_EN) run++;
        else if (run > 0) begin
          chk("ro_en_len", 64'(run), 64'(exp_win));
          run = 0;
        end
        if (ifc.BUSY) busy_cyc++;
        if (ifc.DONE) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (ifc.RES_VALID) begin
          if (!prev_v) begin
            if (exp_q.size() == 0) begin
              n_vec++;
              n_bad++;
              $display("FAIL unexpected_result: got id %0d expected no result", ifc.RES_ID);
            end else begin
              e = exp_q.pop_front();
              chk("res_id", 64'(ifc.RES_ID), 64'(e.id));
              chk("res_cnt", 64'(ifc.RES_CNT), 64'(e.cnt));
              chk("res_tdc", 64'(ifc.RES_TDC), 64'(e.tdc));
              if (!first_seen) chk("first_latency", 64'(cyc - t0), 64'(exp_lat));
              first_seen = 1;
            end
          end else begin
            chk("stall_id", 64'(ifc.RES_ID), 64'(h_id));
            chk("stall_cnt", 64'(ifc.RES_CNT), 64'(h_cnt));
            chk("stall_tdc", 64'(ifc.RES_TDC), 64'(h_tdc));
          end
          chk("ro_sel_held", 64'(ifc.RO_SEL), 64'(9'd1 << ifc.RES_ID));
          h_id = ifc.RES_ID;
          h_cnt = ifc.RES_CNT;
          h_tdc = ifc.RES_TDC;
        end
        prev_v = ifc.RES_VALID && !ifc.RES_READY;
      end
    end
  end

  task automatic rand_tabs();
    for (int i = 0; i < 9; i++) begin
      cnt_tab[i] = 16'($urandom);
      tdc_tab[i] = 48'({$urandom, $urandom});
    end
  endtask

  task automatic wait_ro_en();
    for (int k = 0; k < 200 && !ifc.RO_EN; k++) begin
      @(posedge clk);
      #1;
    end
    if (!ifc.RO_EN) chk("ro_en_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_sweep(input logic [8:0] m, input logic [7:0] w, input int stall,
                           input bit rnd, input bit disturb, input bit abort);
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      if (m[i]) begin
        e.id  = 4'(i);
        e.cnt = cnt_tab[i];
        e.tdc = 6'($countones(tdc_tab[i]));
        exp_q.push_back(e);
      end
    end
    exp_win    = (w == 0) ? 1 : int'(w);
    exp_lat    = 1 + 4 + exp_win + 3 + 1;
    first_seen = 0;
    done_cnt   = 0;
    busy_cyc   = 0;
    rdy_hold   = stall;
    rdy_rand   = rnd;
    @(posedge clk);
    #1;
    ifc.MASK   = m;
    ifc.WINDOW = w;
    ifc.START  = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    ifc.START  = 1'b0;
    ifc.MASK   = 9'($urandom);
    ifc.WINDOW = 8'($urandom);
    if (disturb) begin
      wait_ro_en();
      ifc.START = 1'b1;
      ifc.MASK  = 9'h1FF;
      @(posedge clk);
      #1;
      ifc.START = 1'b0;
    end
    if (abort) begin
      wait_ro_en();
      #2 rst = 1'b1;
      #1;
      chk("abort_ro_en", 64'(ifc.RO_EN), 64'd0);
      chk("abort_ro_sel", 64'(ifc.RO_SEL), 64'd0);
      chk("abort_rstlow", 64'(ifc.CNT_RSTLOW), 64'd1);
      chk("abort_busy", 64'(ifc.BUSY), 64'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      return;
    end
    for (int k = 0; k < 4000 && done_cnt == 0; k++) @(posedge clk);
    if (done_cnt == 0) chk("done_timeout", 64'd0, 64'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("results_left", 64'(exp_q.size()), 64'd0);
    chk("busy_after", 64'(ifc.BUSY), 64'd0);
    if (m == 0) begin
      chk("empty_done_lat", 64'(done_cyc - t0), 64'd2);
      chk("empty_busy_cyc", 64'(busy_cyc), 64'd1);
    end
    exp_q.delete();
  endtask

  initial begin
    ifc.START  = 1'b0;
    ifc.MASK   = '0;
    ifc.WINDOW = '0;
    rand_tabs();
    repeat (2) @(negedge clk);
    chk("rst_ro_sel", 64'(ifc.RO_SEL), 64'd0);
    chk("rst_mux_sel", 64'(ifc.MUX_SEL), 64'd0);
    chk("rst_ro_en", 64'(ifc.RO_EN), 64'd0);
    chk("rst_rstlow", 64'(ifc.CNT_RSTLOW), 64'd1);
    chk("rst_res", 64'({ifc.RES_VALID, ifc.RES_ID, ifc.RES_CNT, ifc.RES_TDC}), 64'd0);
    chk("rst_busy_done", 64'({ifc.BUSY, ifc.DONE}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    cnt_tab[0] = 16'h1234;
    tdc_tab[0] = 48'h0000_00FF_FFFF;
    run_sweep(9'h001, 8'd10, 0, 0, 0, 0);
    rand_tabs();
    run_sweep(9'h1A5, 8'd7, 0, 0, 0, 0);
    rand_tabs();
    run_sweep(9'h003, 8'd10, 20, 0, 0, 0);
    run_sweep(9'h000, 8'd10, 0, 0, 0, 0);
    run_sweep(9'h001, 8'd0, 0, 0, 0, 0);
    rand_tabs();
    run_sweep(9'h012, 8'd12, 0, 0, 1, 0);
    run_sweep(9'h0F0, 8'd8, 0, 0, 0, 1);
    run_sweep(9'h0F0, 8'd8, 0, 0, 0, 0);
    tdc_tab[3] = 48'hFFFF_FFFF_FFFF;
    tdc_tab[4] = 48'h0000_0000_00F7;
    run_sweep(9'h018, 8'd5, 0, 0, 0, 0);
    for (int n = 0; n < 8; n++) begin
      rand_tabs();
      run_sweep(9'($urandom), 8'($urandom_range(0, 20)), 0, 1, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vt_meas_sequencer.md
Name: vt_meas_sequencer

Overview:
- On-chip measurement sequencer that feeds the VT sensor core directly, in place of a host driving control bits over SPI.
- Sweeps the selected sensor ROs one at a time and, for each RO, drives the one-hot RO select, RO mux select, counter reset and RO enable window.
- After each window, captures the ripple-counter value and the 48-step TDC thermometer code, encodes the TDC code, and emits one result per RO on a valid/ready interface.

Parameters:
- NUM_RO, 9, number of sensor ROs (one-hot select width).
- CNT_W, 16, RO ripple-counter width.
- TDC_W, 48, TDC thermometer width.
- TDC_ENC_W, 6, encoded TDC width (ceil log2(TDC_W+1)).
- SETTLE, 4, cycles of RO select plus counter reset before the enable window.
- CAP_DLY, 3, cycles after the enable falls before capture, so ripple and TDC outputs settle.

Ports:
- CLK  in  1  sequencer clock.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  single-cycle sweep request.
- MASK  in  NUM_RO  ROs to measure; bit i maps to RO i.
- WINDOW  in  8  enable-window length in CLK cycles.
- RO_SEL  out  NUM_RO  one-hot RO select.
- MUX_SEL  out  4  RO mux select (binary index of the active RO).
- RO_EN  out  1  sensor RO enable; its inverse is the TDC reference.
- CNT_RSTLOW  out  1  active-low RO counter reset.
- CNT_IN  in  CNT_W  RO counter value.
- TDC_IN  in  TDC_W  TDC thermometer code.
- RES_VALID  out  1  result valid.
- RES_READY  in  1  result accepted by the consumer.
- RES_ID  out  4  RO index of the current result.
- RES_CNT  out  CNT_W  captured counter value.
- RES_TDC  out  TDC_ENC_W  encoded TDC value.
- BUSY  out  1  sweep in progress.
- DONE  out  1  one-cycle pulse at the end of a sweep.

Behaviour:
- Reset values: RO_SEL=0, MUX_SEL=0, RO_EN=0, CNT_RSTLOW=1, RES_*=0, RES_VALID=0, BUSY=0, DONE=0, FSM=IDLE. Reset asserted mid-sweep aborts immediately; there is no resume.
- All outputs are registered.
- FSM states: IDLE, SELECT, RUN, HOLD, CAPTURE, WAIT, FINISH.
- IDLE:
  - On START, latch MASK and WINDOW into shadow registers and set BUSY=1.
  - If the latched MASK is 0, go to FINISH; otherwise go to SELECT with index = lowest set MASK bit.
- SELECT:
  - Drive RO_SEL=1<<idx, MUX_SEL=idx, CNT_RSTLOW=0 for SETTLE cycles.
  - Then set CNT_RSTLOW=1 and go to RUN.
- RUN:
  - Drive RO_EN=1 for max(WINDOW,1) cycles; WINDOW=0 is treated as 1.
  - Then set RO_EN=0 and go to HOLD.
- HOLD:
  - Wait CAP_DLY cycles, keeping RO_SEL and MUX_SEL stable.
  - CNT_IN and TDC_IN are asynchronous-domain signals but static here.
- CAPTURE (1 cycle):
  - Register RES_CNT=CNT_IN, RES_TDC=popcount(TDC_IN), RES_ID=idx.
  - Set RES_VALID=1 and go to WAIT.
  - popcount is bubble-tolerant; a maximum of 48 fits in 6 bits.
- WAIT:
  - Hold RES_* stable while RES_VALID=1.
  - On a clock edge with RES_READY=1, clear RES_VALID, then:
    - if a higher set bit exists in the latched MASK, go to SELECT with the next index;
    - otherwise go to FINISH.
  - If RES_READY is already high on the first WAIT cycle, the transfer completes at that edge.
- FINISH (1 cycle): DONE=1, BUSY=0, RO_SEL=0, then return to IDLE.
- Single-RO latency from START edge to RES_VALID: 1+SETTLE+max(WINDOW,1)+CAP_DLY+1 cycles. With defaults and WINDOW=10, this is 19.
- START while BUSY=1 is ignored. MASK and WINDOW changes during a sweep are ignored.
- MASK bits at or above NUM_RO do not exist. Indices are visited in ascending order, each exactly once.
- Only one RO_SEL bit is ever high. RO_EN is never high outside RUN. CNT_RSTLOW is never low while RO_EN=1.

Decomposition:
- Shared package vt_pkg holds:
  - state enum;
  - NUM_RO, CNT_W, TDC_W, TDC_ENC_W constants;
  - RO index encoding (0=inv_hvt … 8=nor4_rvt).
- One sub-module: vt_therm_encoder, a combinational popcount of TDC_W to TDC_ENC_W, reused by any host-side decoder.

Test Plan:
- MASK=9'h001, WINDOW=10, CNT_IN=16'h1234, TDC_IN=48'h0000_00FF_FFFF, RES_READY=1 -> RES_VALID at cycle 19 with RES_ID=0, RES_CNT=16'h1234, RES_TDC=24; DONE pulses 2 cycles later; RO_EN high for exactly 10 cycles.
- MASK=9'h1A5, RES_READY=1 -> results carry RES_ID 0,2,5,7,8 in order; RO_SEL always one-hot and matching MUX_SEL; one DONE.
- MASK=9'h003, RES_READY held low 20 cycles on the first result -> RES_* stable and RES_VALID high throughout; RO_SEL stays 1; the second RO is not started until acceptance.
- MASK=0 -> DONE at START+2, BUSY high 1 cycle, RES_VALID never asserted; WINDOW=0 with MASK=1 -> RO_EN high exactly 1 cycle.
- START pulsed again during RUN, with MASK changed to 9'h1FF -> ignored; the original sweep completes unchanged.
- RST asserted during RUN -> RO_EN=0, RO_SEL=0, CNT_RSTLOW=1, BUSY=0 asynchronously; a new START after release sweeps normally.
- TDC_IN=48'hFFFF_FFFF_FFFF gives RES_TDC=48; bubble code 48'h0000_0000_00F7 gives RES_TDC=7.
